// File: rtl/wb_lfsr_gen.sv
// Wishbone-classic LFSR peripheral: programmable taps/seed, Fibonacci or Galois, free-run or counted steps.
// Optional step-done interrupt is built only when WB_LFSR_IRQ_EN is defined.
module wb_lfsr_gen #(
    parameter int          WIDTH        = 32,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] DEFAULT_TAPS = 32'h80200003,
    parameter logic [31:0] DEFAULT_SEED = 32'h1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    output logic             o_lfsr_bit,
    output logic [WIDTH-1:0] o_lfsr_word,
    output logic             o_irq
);

    localparam logic [WIDTH-1:0] TAPS_RST = DEFAULT_TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_RST = DEFAULT_SEED[WIDTH-1:0];

    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             run_q, run_d;
    logic             galois_q, galois_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             access, wr;
    logic             ctrl_wr, stat_wr, step_wr;
    logic             load, adv, busy, lockup;
    logic [WIDTH-1:0] step_val;
    logic [31:0]      rd_mux;
    logic             irq_en, irq_pend;

    always_comb begin
        access   = i_wb_cyc & i_wb_stb;
        wr       = access & i_wb_we;
        ctrl_wr  = wr && (i_wb_addr == 3'd0);
        stat_wr  = wr && (i_wb_addr == 3'd1);
        step_wr  = wr && (i_wb_addr == 3'd5);
        load     = ctrl_wr & i_wb_data[1];
        busy     = run_q | (cnt_q != '0);
        adv      = busy;
        lockup   = (state_q == '0);

        if (galois_q)
            step_val = (state_q >> 1) ^ (state_q[0] ? taps_q : '0);
        else
            step_val = {state_q[WIDTH-2:0], ^(state_q & taps_q)};

        run_d    = ctrl_wr ? i_wb_data[0] : run_q;
        galois_d = ctrl_wr ? i_wb_data[2] : galois_q;
        taps_d   = (wr && i_wb_addr == 3'd2) ? i_wb_data[WIDTH-1:0] : taps_q;
        seed_d   = (wr && i_wb_addr == 3'd3) ? i_wb_data[WIDTH-1:0] : seed_q;

        // Only one bus write per cycle, so seed_q already is the post-write seed during a load.
        state_d = state_q;
        if (load)
            state_d = seed_q;
        else if (adv)
            state_d = step_val;

        cnt_d = cnt_q;
        if (step_wr)
            cnt_d = i_wb_data[CNT_W-1:0];
        else if (!load && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);

        rd_mux = '0;
        case (i_wb_addr)
            3'd0: begin
                rd_mux[0] = run_q;
                rd_mux[2] = galois_q;
                rd_mux[3] = irq_en;
            end
            3'd1: begin
                rd_mux[0] = busy;
                rd_mux[1] = lockup;
                rd_mux[2] = irq_pend;
            end
            3'd2: rd_mux[WIDTH-1:0] = taps_q;
            3'd3: rd_mux[WIDTH-1:0] = seed_q;
            3'd4: rd_mux[WIDTH-1:0] = state_q;
            3'd5: rd_mux[CNT_W-1:0] = cnt_q;
            default: rd_mux = '0;
        endcase

        ack_d   = access;
        rdata_d = (access && !i_wb_we) ? rd_mux : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            run_q    <= 1'b0;
            galois_q <= 1'b0;
            taps_q   <= TAPS_RST;
            seed_q   <= SEED_RST;
            state_q  <= SEED_RST;
            cnt_q    <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            run_q    <= run_d;
            galois_q <= galois_d;
            taps_q   <= taps_d;
            seed_q   <= seed_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef WB_LFSR_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_pend_q, irq_pend_d;

    always_comb begin
        irq_en_d   = ctrl_wr ? i_wb_data[3] : irq_en_q;
        irq_pend_d = irq_pend_q;
        if (stat_wr && i_wb_data[2])
            irq_pend_d = 1'b0;
        // Completion is applied after the clear so a same-cycle W1C cannot lose it.
        if (cnt_q == CNT_W'(1) && cnt_d == '0)
            irq_pend_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_en   = irq_en_q;
    assign irq_pend = irq_pend_q;
    assign o_irq    = irq_pend_q & irq_en_q;
`else
    assign irq_en   = 1'b0;
    assign irq_pend = 1'b0;
    assign o_irq    = 1'b0;
`endif

    assign o_wb_stall  = 1'b0;
    assign o_wb_ack    = ack_q;
    assign o_wb_data   = rdata_q;
    assign o_lfsr_word = state_q;
    assign o_lfsr_bit  = galois_q ? state_q[0] : state_q[WIDTH-1];

endmodule

// File: tb/tb_wb_lfsr_gen.sv
// Directed bench for wb_lfsr_gen at WIDTH=8; interrupt checks follow WB_LFSR_IRQ_EN.
module tb_wb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        stall, ack, lbit, irq;
    logic [31:0] rdata;
    logic [7:0]  word;

    int ncmp = 0;
    int nerr = 0;

    wb_lfsr_gen #(.WIDTH(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata),
        .o_lfsr_bit(lbit), .o_lfsr_word(word), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        chk("write_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; wdata = '0;
        @(posedge clk); #1;
        chk("read_ack", {31'd0, ack}, 32'd1);
        d = rdata;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        saw_bad;

    initial begin
        cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_word", {24'd0, word}, 32'h01);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        wb_read(3'd4, rd); chk("reset_state_rd", rd, 32'h01);
        wb_read(3'd2, rd); chk("reset_taps_rd", rd, 32'h03);
        wb_read(3'd1, rd); chk("reset_stat_rd", rd, 32'h0);
        tick();
        chk("ack_drops", {31'd0, ack}, 32'd0);

        // Counted Fibonacci steps
        wb_write(3'd2, 32'hB8);
        wb_write(3'd3, 32'h01);
        wb_write(3'd0, 32'h02);
        chk("load_word", {24'd0, word}, 32'h01);
        wb_write(3'd5, 32'd3);
        chk("step_no_adv_yet", {24'd0, word}, 32'h01);
        wb_read(3'd1, rd);
        chk("stat_busy", rd, 32'h1);
        chk("fib_step1", {24'd0, word}, 32'h02);
        tick(); chk("fib_step2", {24'd0, word}, 32'h04);
        tick(); chk("fib_step3", {24'd0, word}, 32'h08);
        tick(); chk("fib_hold", {24'd0, word}, 32'h08);
        wb_read(3'd1, rd); chk("stat_idle", rd, 32'h0);
        wb_read(3'd5, rd); chk("step_remaining", rd, 32'h0);
        chk("fib_bit", {31'd0, lbit}, 32'd0);

        // Galois single step
        wb_write(3'd0, 32'h06);
        chk("galois_load", {24'd0, word}, 32'h01);
        wb_write(3'd5, 32'd1);
        tick(); chk("galois_step", {24'd0, word}, 32'hB8);
        chk("galois_bit", {31'd0, lbit}, 32'd0);
        wb_read(3'd4, rd); chk("galois_state_rd", rd, 32'hB8);
        wb_read(3'd0, rd); chk("ctrl_rd", rd, 32'h04);

        // Free-run Fibonacci: full period of 255
        wb_write(3'd0, 32'h02);
        chk("reload_word", {24'd0, word}, 32'h01);
        wb_write(3'd0, 32'h01);
        saw_bad = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i < 255 && (word == 8'h00 || word == 8'h01)) saw_bad = 1'b1;
        end
        chk("period_no_zero_or_early", {31'd0, saw_bad}, 32'd0);
        chk("period_255", {24'd0, word}, 32'h01);
        wb_write(3'd0, 32'h00);
        chk("run_stop_step", {24'd0, word}, 32'h02);
        tick(); chk("run_stopped_hold", {24'd0, word}, 32'h02);

        // Lockup
        wb_write(3'd3, 32'h00);
        wb_write(3'd0, 32'h02);
        chk("lockup_word", {24'd0, word}, 32'h00);
        wb_read(3'd1, rd); chk("stat_lockup", rd, 32'h2);
        wb_write(3'd5, 32'd5);
        repeat (6) tick();
        chk("lockup_hold", {24'd0, word}, 32'h00);
        wb_write(3'd5, 32'd10);
        wb_write(3'd5, 32'd0);
        wb_read(3'd1, rd); chk("step_cancel", rd, 32'h2);

        // Masking and unmapped addresses
        wb_write(3'd2, 32'hFFFF_FFFF);
        wb_read(3'd2, rd); chk("taps_mask", rd, 32'hFF);
        wb_write(3'd6, 32'hDEAD_BEEF);
        wb_read(3'd6, rd); chk("addr6_zero", rd, 32'h0);
        wb_read(3'd7, rd); chk("addr7_zero", rd, 32'h0);

`ifdef WB_LFSR_IRQ_EN
        wb_write(3'd2, 32'hB8);
        wb_write(3'd3, 32'h01);
        wb_write(3'd0, 32'h0A);
        wb_write(3'd5, 32'd2);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        tick(); chk("irq_one_left", {31'd0, irq}, 32'd0);
        tick(); chk("irq_rise", {31'd0, irq}, 32'd1);
        wb_read(3'd1, rd); chk("stat_irq_pend", rd, 32'h4);
        wb_write(3'd1, 32'h4);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
`else
        wb_write(3'd0, 32'h08);
        wb_read(3'd0, rd); chk("ctrl_irq_en_absent", rd, 32'h0);
        wb_write(3'd5, 32'd1);
        repeat (2) tick();
        chk("irq_tied_low", {31'd0, irq}, 32'd0);
        wb_read(3'd1, rd); chk("stat_no_pend", rd, 32'h2);
`endif

        // Reset mid-operation
        wb_write(3'd2, 32'hB8);
        wb_write(3'd3, 32'h5A);
        wb_write(3'd0, 32'h03);
        tick();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd4;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_ack", {31'd0, ack}, 32'd0);
        chk("midreset_word", {24'd0, word}, 32'h01);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wb_read(3'd2, rd); chk("midreset_taps", rd, 32'h03);
        wb_read(3'd0, rd); chk("midreset_ctrl", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
